// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - mdu_op_e    : operation encodings as driven on the op port
//   - mdu_state_e : sequencer states
//   - abs_val     : magnitude of a value held in MDU_MAX_W bits. The caller
//                   extends the operand to MDU_MAX_W: sign-extension for
//                   signed ops, zero-extension otherwise.
//                   WIDTH of any user must not exceed MDU_MAX_W.
package mdu_pkg;

  localparam int unsigned MDU_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic [MDU_MAX_W-1:0] abs_val(input logic [MDU_MAX_W-1:0] x,
                                                   input logic                 is_signed);
    return (is_signed && x[MDU_MAX_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Loadable iteration down counter for the multiply/divide unit.
//   clk   : clock
//   rst   : synchronous reset, active-low
//   load  : load the value WIDTH (has priority over dec)
//   dec   : decrement by one; holds at zero
//   count : current count
//   zero  : count is zero
module mdu_cycle_counter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(WIDTH);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit owning the HI/LO registers.
// Multiply: radix-2 shift-add on magnitudes; divide: restoring, one quotient
// bit per cycle. Signs are stripped at launch and restored in FIX.
// Optional divider: define MDU_DIV_EN to build div/divu. Without it, div ops
// run with multiply latency and commit hi=lo=0.
//   clk, rst          : clock; synchronous active-low reset
//   start, op, a, b   : launch (accepted in IDLE/DONE), op code, operands
//   mthi_we, mtlo_we  : write wdata to hi/lo when not busy
//   wdata             : mthi/mtlo data
//   hi, lo            : architectural HI/LO
//   busy              : CALC or FIX in progress
//   done              : one-cycle pulse after hi/lo commit
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d, op_in;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [CNT_W-1:0]   cnt;

  logic               is_signed, sign_a, sign_b, is_div_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, fix_prod;

`ifdef MDU_DIV_EN
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff, fix_quot, fix_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
`endif

  mdu_cycle_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .count (cnt),
    .zero  (cnt_zero)
  );

  assign cnt_last = (cnt == CNT_W'(1));
  assign is_div_q = (op_q inside {OP_DIV, OP_DIVU});

  // Launch-side operand conditioning.
  always_comb begin
    op_in     = mdu_op_e'(op);
    is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    sign_a    = is_signed & a[WIDTH-1];
    sign_b    = is_signed & b[WIDTH-1];
    mag_a = WIDTH'(abs_val(is_signed ? MDU_MAX_W'(signed'(a)) : MDU_MAX_W'(a), is_signed));
    mag_b = WIDTH'(abs_val(is_signed ? MDU_MAX_W'(signed'(b)) : MDU_MAX_W'(b), is_signed));
  end

  // Iteration and sign-correction datapath.
  always_comb begin
    // acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    fix_prod = neg_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    // acc = {partial remainder, dividend bits shifting into quotient}.
    // A zero divisor makes every step succeed, so the quotient fills with
    // ones and the remainder ends up as the dividend magnitude.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_diff  = WIDTH'(div_shift - {1'b0, mcand_q});
    div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    fix_quot  = bzero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    fix_rem   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  // Sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef MDU_DIV_EN
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mthi_we) hi_d = wdata;
        if (mtlo_we) lo_d = wdata;
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_CALC;
          cnt_load = 1'b1;
          op_d     = op_in;
          neg_d    = sign_a ^ sign_b;
          acc_d    = {{WIDTH{1'b0}}, mag_b};
          mcand_d  = mag_a;
`ifdef MDU_DIV_EN
          rem_neg_d = sign_a;
          bzero_d   = (b == '0);
          if (op_in inside {OP_DIV, OP_DIVU}) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            mcand_d = mag_b;
          end
`endif
        end
      end
      ST_CALC: begin
        cnt_dec = 1'b1;
        if (!cnt_zero) begin
          acc_d = mul_next;
`ifdef MDU_DIV_EN
          if (is_div_q) acc_d = div_next;
`endif
        end
        if (cnt_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        hi_d    = fix_prod[2*WIDTH-1:WIDTH];
        lo_d    = fix_prod[WIDTH-1:0];
        if (is_div_q) begin
`ifdef MDU_DIV_EN
          hi_d = fix_rem;
          lo_d = fix_quot;
`else
          hi_d = '0;
          lo_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);

endmodule
